// File: rtl/pc_seq_pkg.sv
// Shared constants and types for the next-PC sequencer: opcodes, flag
// indices, the sequencer state encoding and the branch-condition helper.
package pc_seq_pkg;

  localparam logic [4:0] OP_BR   = 5'h10;
  localparam logic [4:0] OP_CALL = 5'h11;
  localparam logic [4:0] OP_RET  = 5'h12;
  localparam logic [4:0] OP_RETI = 5'h13;

  localparam logic [2:0] FLAG_Z = 3'd0;
  localparam logic [2:0] FLAG_O = 3'd1;
  localparam logic [2:0] FLAG_N = 3'd2;
  localparam logic [2:0] FLAG_C = 3'd3;
  localparam logic [2:0] FLAG_I = 3'd4;
  localparam logic [2:0] FLAG_A = 3'd5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    IRQ_PUSH = 2'd2,
    IRQ_VEC  = 2'd3
  } seq_state_t;

  // Flag bits 6/7 are unpopulated, so selecting them never takes the
  // branch, even when inverted. FLAG_A is tied high upstream, which makes
  // cond_sel=5 the unconditional form.
  function automatic logic cond_taken(input logic [7:0] flags,
                                      input logic [2:0] sel,
                                      input logic       neg);
    if (sel > FLAG_A) return 1'b0;
    return flags[sel] ^ neg;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Hardware return stack: LIFO of return addresses with a combinational
// top-of-stack read. Pushes when full and pops when empty are ignored;
// the owner decides how to flag them.
module ret_stack #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [CW-1:0]   sp_q, sp_d;
  logic [PC_W-1:0] mem_q [STACK_DEPTH];
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  assign full   = (sp_q == CW'(STACK_DEPTH));
  assign empty  = (sp_q == '0);
  assign wr_idx = sp_q[AW-1:0];
  assign rd_idx = sp_q[AW-1:0] - AW'(1);
  assign dout   = mem_q[rd_idx];

  // Stack pointer next value; push and pop are mutually exclusive upstream.
  always_comb begin
    // NOTE: assigning a default first on every path keeps this block purely
    // combinational; a missing else would otherwise infer a latch.
    sp_d = sp_q;
    if (push && !full)       sp_d = sp_q + CW'(1);
    else if (pop && !empty)  sp_d = sp_q - CW'(1);
  end

  // Stack pointer register; clearing it empties the stack on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  // Entry storage; only writes on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is deliberately not reset. Contents above the
    // pointer are never read, so clearing sp_q alone discards the stack.
    if (push && !full) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC generator: evaluates branch conditions against the flag vector,
// drives CALL/RET through the return stack and sequences interrupt entry.
// All outputs are registered; stall freezes every register in place.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W        = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] IRQ_VECTOR  = PC_W'(8'hF0)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic [4:0]      instr_op,
  input  logic [2:0]      cond_sel,
  input  logic            cond_neg,
  input  logic [PC_W-1:0] target,
  input  logic [7:0]      flags,
  input  logic            irq,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            irq_ack,
  output logic            reti_pulse,
  output logic            stack_err
);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            irq_ack_q, irq_ack_d;
  logic            reti_pulse_q, reti_pulse_d;
  logic            stack_err_q, stack_err_d;

  logic            stk_push, stk_pop;
  logic [PC_W-1:0] stk_din, stk_dout;
  logic            stk_full, stk_empty;
  logic [PC_W-1:0] pc_inc;
  logic            taken;

  assign pc_inc = pc_q + PC_W'(1);
  assign taken  = cond_taken(flags, cond_sel, cond_neg);

  ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (stk_din),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Next-state, next-pc and output decode; everything holds while stalled.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_valid_d   = pc_valid_q;
    irq_ack_d    = irq_ack_q;
    reti_pulse_d = reti_pulse_q;
    stack_err_d  = stack_err_q;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    stk_din      = pc_inc;

    if (!stall) begin
      irq_ack_d    = 1'b0;
      reti_pulse_d = 1'b0;
      unique case (state_q)
        RUN: begin
          if (irq && flags[FLAG_I]) begin
            // Discard the current instruction; its pc is pushed next cycle
            // so RETI re-executes it.
            state_d    = IRQ_PUSH;
            pc_valid_d = 1'b0;
          end else begin
            unique case (instr_op)
              OP_BR: begin
                if (taken) begin
                  pc_d       = target;
                  state_d    = FLUSH;
                  pc_valid_d = 1'b0;
                end else begin
                  pc_d = pc_inc;
                end
              end
              OP_CALL: begin
                if (taken) begin
                  stk_push   = 1'b1;
                  stk_din    = pc_inc;
                  if (stk_full) stack_err_d = 1'b1;
                  pc_d       = target;
                  state_d    = FLUSH;
                  pc_valid_d = 1'b0;
                end else begin
                  pc_d = pc_inc;
                end
              end
              OP_RET, OP_RETI: begin
                stk_pop = 1'b1;
                if (stk_empty) begin
                  pc_d        = pc_inc;
                  stack_err_d = 1'b1;
                end else begin
                  pc_d = stk_dout;
                end
                reti_pulse_d = (instr_op == OP_RETI);
                state_d      = FLUSH;
                pc_valid_d   = 1'b0;
              end
              default: pc_d = pc_inc;
            endcase
          end
        end
        FLUSH: begin
          state_d    = RUN;
          pc_valid_d = 1'b1;
        end
        IRQ_PUSH: begin
          stk_push  = 1'b1;
          stk_din   = pc_q;
          if (stk_full) stack_err_d = 1'b1;
          state_d   = IRQ_VEC;
          irq_ack_d = 1'b1;
        end
        IRQ_VEC: begin
          pc_d       = IRQ_VECTOR;
          state_d    = RUN;
          pc_valid_d = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= '0;
      pc_valid_q   <= 1'b1;
      irq_ack_q    <= 1'b0;
      reti_pulse_q <= 1'b0;
      stack_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      irq_ack_q    <= irq_ack_d;
      reti_pulse_q <= reti_pulse_d;
      stack_err_q  <= stack_err_d;
    end
  end

  assign pc         = pc_q;
  assign pc_valid   = pc_valid_q;
  assign irq_ack    = irq_ack_q;
  assign reti_pulse = reti_pulse_q;
  assign stack_err  = stack_err_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC generator that consumes the 8-bit flag vector (Z=0, O=1, N=2, C=3, I=4, A=5, bits 6/7 empty) from the flag register.
- Evaluates branch conditions and maintains a hardware return stack for CALL/RET.
- Sequences interrupt entry when irq is asserted and the I flag is set.
- Sits between the flag register and instruction fetch; drives the fetch address each cycle.

Parameters:
- PC_W, 8, program counter width.
- STACK_DEPTH, 4, return-stack entries (power of 2, >=2).
- IRQ_VECTOR, 8'hF0, interrupt entry address (PC_W bits).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  freeze all state (FSM, pc, stack); outputs hold.
- instr_op  in  5  opcode of the instruction at the current pc.
- cond_sel  in  3  flag index tested by BR/CALL.
- cond_neg  in  1  invert condition.
- target  in  PC_W  branch/call destination.
- flags  in  8  flag register output.
- irq  in  1  level interrupt request.
- pc  out  PC_W  fetch address.
- pc_valid  out  1  pc holds a real fetch; 0 during bubbles.
- irq_ack  out  1  one-cycle pulse on vector load.
- reti_pulse  out  1  one-cycle pulse when RETI retires; flag control uses it to set I.
- stack_err  out  1  sticky over/underflow indicator.

Behaviour:
- Reset (async, rst_n=0): pc=0, pc_valid=1, state RUN, stack empty, stack_err=0, irq_ack=0, reti_pulse=0.
- Opcodes:
  - BR=5'h10: conditional jump.
  - CALL=5'h11: conditional call.
  - RET=5'h12: return.
  - RETI=5'h13: return from interrupt.
  - All other values: sequential.
- Condition: taken = flags[cond_sel] ^ cond_neg for cond_sel 0..5. For cond_sel 6 or 7, taken = 0 regardless of cond_neg. cond_sel=5 (A) gives an unconditional branch.
- FSM states: RUN, FLUSH, IRQ_PUSH, IRQ_VEC. All transitions happen only when stall=0.
- RUN, interrupt (irq=1 and flags[4]=1): the current instruction is discarded, nothing else updates, next state IRQ_PUSH, pc_valid=0 from the next cycle.
- RUN, otherwise, the current op executes:
  - Sequential: pc <= pc+1, wrapping 2^PC_W-1 -> 0.
  - BR taken: pc <= target, next FLUSH.
  - BR not taken: pc+1.
  - CALL taken: push pc+1 (wrapped), pc <= target, next FLUSH.
  - CALL not taken: pc+1.
  - RET: pop into pc, next FLUSH.
  - RETI: pop into pc, reti_pulse=1 next cycle, next FLUSH.
- FLUSH: pc_valid=0 for exactly one cycle, pc held, irq ignored, then RUN with pc_valid=1.
- IRQ_PUSH: push the discarded instruction's pc (it re-executes on RETI), pc_valid=0, next IRQ_VEC.
- IRQ_VEC: pc <= IRQ_VECTOR, irq_ack=1 for this cycle only, pc_valid=0, next RUN.
- Latency:
  - Taken branch: 2 cycles to first valid fetch at target.
  - Interrupt: 3 cycles from acceptance to pc_valid=1 at IRQ_VECTOR.
- Stack boundaries:
  - Push when full: push dropped, stack_err <= 1, control flow proceeds to target anyway.
  - Pop when empty: pc <= pc+1, stack_err <= 1, FLUSH still entered, reti_pulse still fires for RETI.
  - stack_err clears only on reset.
- Push and pop never occur in the same cycle by construction.
- stall=1 in any state: hold all registers. Pulses stretch while stalled; they assert only in the cycle after the triggering transition.
- rst_n low mid-interrupt-entry or mid-FLUSH: immediate return to reset state; stack contents discarded.

Decomposition:
- Package pc_seq_pkg:
  - Opcode localparams OP_BR, OP_CALL, OP_RET, OP_RETI.
  - Flag-index constants FLAG_Z..FLAG_A.
  - State enum seq_state_t {RUN, FLUSH, IRQ_PUSH, IRQ_VEC}.
- Sub-module ret_stack:
  - Parameters PC_W and STACK_DEPTH.
  - Ports: push, pop, din, dout, full, empty, async reset.
  - Combinational top-of-stack read.

Test Plan:
- Reset then 3 NOP cycles (instr_op=5'h00) -> pc 0,1,2,3, pc_valid=1 throughout; at PC_W=8 starting pc=8'hFF, NOP -> pc=8'h00.
- BR with cond_sel=0, flags=8'h21, target=8'h40 -> next cycle pc=8'h40 with pc_valid=0, following cycle pc_valid=1. Same with flags=8'h20 -> pc+1, no bubble. cond_sel=6 with cond_neg=1 -> not taken.
- CALL at pc=8'h05, target 8'h30 (cond_sel=5), then RET at 8'h30 -> pc=8'h06 after FLUSH, stack empty, stack_err=0.
- irq=1, flags=8'h30, pc=8'h12 -> IRQ_PUSH, then IRQ_VEC with irq_ack=1, then pc=8'hF0 valid. RETI -> pc=8'h12 and reti_pulse=1. Repeat with flags=8'h20 -> irq ignored.
- Five nested taken CALLs with STACK_DEPTH=4 -> stack_err=1 after the 5th, 4 RETs return correctly. A 5th RET (underflow) -> pc+1, stack_err stays 1.
- stall=1 held 3 cycles during IRQ_PUSH -> pc, state, irq_ack frozen. Release -> sequence resumes. rst_n pulsed low during FLUSH -> pc=0, stack empty immediately.
